// File: rtl/ex_retire_stage_pkg.sv
// ex_retire_stage_pkg: shared types for the ALU retire stage.
//   csr_t        ALU condition flags {Sign, Zero, Carry, Overflow}
//   exr_entry_t  one buffered ALU result with its destination and write enables
//   exr_state_t  occupancy of the 2-entry skid buffer
package ex_retire_stage_pkg;

  localparam int EXR_DATA_W = 16;
  localparam int EXR_RD_W   = 3;

  typedef struct packed {
    logic s;
    logic z;
    logic c;
    logic v;
  } csr_t;

  typedef struct packed {
    logic [EXR_DATA_W-1:0] result;
    csr_t                  csr;
    logic [EXR_RD_W-1:0]   rd;
    logic                  wr_reg;
    logic                  wr_csr;
  } exr_entry_t;

  typedef enum logic [1:0] {
    EXR_EMPTY = 2'd0,
    EXR_ONE   = 2'd1,
    EXR_FULL  = 2'd2
  } exr_state_t;

endpackage

// File: rtl/ex_retire_stage_flag_reg.sv
// exr_flag_reg: architectural flag register and retired-instruction counter.
// Both advance only on the retire strobe, independent of flush.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   i_retire     head entry retires this cycle
//   i_wr_csr     retiring entry updates the flags
//   i_csr        retiring entry's flags
//   o_flags      architectural flags
//   o_cnt        retired count, wraps at 2^CNT_W
module exr_flag_reg
  import ex_retire_stage_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_retire,
  input  logic             i_wr_csr,
  input  csr_t             i_csr,
  output csr_t             o_flags,
  output logic [CNT_W-1:0] o_cnt
);

  csr_t             r_flags;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_flags <= '0;
      r_cnt   <= '0;
    end else if (i_retire) begin
      if (i_wr_csr) r_flags <= i_csr;
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_flags = r_flags;
  assign o_cnt   = r_cnt;

endmodule

// File: rtl/ex_retire_stage.sv
// ex_retire_stage: retire stage after the ALU. Captures result/flags/destination
// into a 2-entry skid buffer (main = head, skid = second) and presents the head
// to register-file writeback. Flags and the retired count update on each pop.
// Optional feature macro: EX_RETIRE_FWD_EN adds fwd_valid/fwd_rd/fwd_result,
// exposing the youngest buffered register-writing entry for operand bypass.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   flush                        drop buffered entries (flags/count kept)
//   in_valid/in_ready            upstream handshake (in_ready = not FULL)
//   in_result/in_csr/in_rd/in_wr_reg/in_wr_csr   incoming ALU entry
//   out_valid/out_ready          writeback handshake
//   out_result/out_rd/out_wr_reg head entry
//   flags_q, retired_cnt         architectural flags, retire counter
// RD_W must not exceed the package EXR_RD_W (slot storage width).
module ex_retire_stage
  import ex_retire_stage_pkg::*;
#(
  parameter int RD_W  = EXR_RD_W,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_result,
  input  csr_t             in_csr,
  input  logic [RD_W-1:0]  in_rd,
  input  logic             in_wr_reg,
  input  logic             in_wr_csr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_result,
  output logic [RD_W-1:0]  out_rd,
  output logic             out_wr_reg,
`ifdef EX_RETIRE_FWD_EN
  output logic             fwd_valid,
  output logic [RD_W-1:0]  fwd_rd,
  output logic [15:0]      fwd_result,
`endif
  output csr_t             flags_q,
  output logic [CNT_W-1:0] retired_cnt
);

  exr_state_t r_state;
  exr_entry_t r_main, r_skid;
  exr_entry_t w_in;
  logic       w_push, w_pop;

  always_comb begin
    w_in        = '0;
    w_in.result = in_result;
    w_in.csr    = in_csr;
    w_in.rd     = EXR_RD_W'(in_rd);
    w_in.wr_reg = in_wr_reg;
    w_in.wr_csr = in_wr_csr;
  end

  // Both handshake flags decode straight from the state register, so neither
  // has a combinational path from the other side's inputs.
  assign in_ready  = (r_state != EXR_FULL);
  assign out_valid = (r_state != EXR_EMPTY);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      // Flush drops the push and the buffer; a same-cycle pop still retires
      // because the flag register sees w_pop directly.
      r_state <= EXR_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      unique case (r_state)
        EXR_EMPTY: if (w_push) begin
          r_main  <= w_in;
          r_state <= EXR_ONE;
        end
        EXR_ONE: begin
          if (w_push && w_pop)   r_main <= w_in;
          else if (w_push) begin
            r_skid  <= w_in;
            r_state <= EXR_FULL;
          end else if (w_pop) begin
            r_main  <= '0;
            r_state <= EXR_EMPTY;
          end
        end
        EXR_FULL: if (w_pop) begin
          r_main  <= r_skid;
          r_skid  <= '0;
          r_state <= EXR_ONE;
        end
        default: r_state <= EXR_EMPTY;
      endcase
    end
  end

  assign out_result = r_main.result;
  assign out_rd     = RD_W'(r_main.rd);
  assign out_wr_reg = r_main.wr_reg & out_valid;

`ifdef EX_RETIRE_FWD_EN
  logic w_skid_fwd, w_main_fwd;
  assign w_skid_fwd = (r_state == EXR_FULL) && r_skid.wr_reg;
  assign w_main_fwd = (r_state != EXR_EMPTY) && r_main.wr_reg;
  assign fwd_valid  = w_skid_fwd | w_main_fwd;
  assign fwd_rd     = w_skid_fwd ? RD_W'(r_skid.rd) : RD_W'(r_main.rd);
  assign fwd_result = w_skid_fwd ? r_skid.result    : r_main.result;
`endif

  exr_flag_reg #(.CNT_W(CNT_W)) u_flag_reg (
    .clk      (clk),
    .rst      (rst),
    .i_retire (w_pop),
    .i_wr_csr (r_main.wr_csr),
    .i_csr    (r_main.csr),
    .o_flags  (flags_q),
    .o_cnt    (retired_cnt)
  );

endmodule
